attn_bitserial_acc_ctrl: RTL
============================

// Module: attn_bitserial_acc_ctrl
// PURPOSE
//  Bit-serial accumulation controller for the attention-score path: sequences one
//  Full_adder cell plus a carry flop to sum a stream of unsigned spike-count terms
//  into an ACC_W-bit accumulator, LSB first, one bit per clock.
//  Sits between the spike-AND/popcount stage (term producer) and the score buffer (sum consumer).
// PARAMETERS
//  DATA_W   8   width of each incoming term; zero-extended to ACC_W
//  ACC_W    16  accumulator width; also the number of SHIFT cycles per term (ACC_W >= DATA_W)
// PORTS
//  s_clk          in   1       clock, all state on rising edge
//  s_rst          in   1       asynchronous, active-high reset
//  i_term         in   DATA_W  term operand
//  i_term_first   in   1       term starts a new sum (accumulator treated as zero)
//  i_term_last    in   1       term ends the current sum
//  i_term_valid   in   1       term/first/last valid
//  o_term_ready   out  1       controller accepts a term this cycle
//  o_sum          out  ACC_W   accumulated result (accumulator register)
//  o_sum_ovf      out  1       sticky: carry out of bit ACC_W-1 occurred in this sum
//  o_sum_valid    out  1       o_sum/o_sum_ovf valid
//  i_sum_ready    in   1       consumer takes the sum
//  o_busy         out  1       high in SHIFT or DONE
// BEHAVIOUR
//  Reset (async, s_rst=1): state=IDLE, acc=0, operand sreg=0, carry=0, bit_cnt=0,
//   clr_flag=0, last_flag=0, ovf=0; outputs: o_term_ready=0 while s_rst=1, o_sum=0,
//   o_sum_ovf=0, o_sum_valid=0, o_busy=0. Reset mid-SHIFT/DONE discards the sum, no output.
//  FSM IDLE -> SHIFT -> (IDLE | DONE) -> IDLE.
//  IDLE: o_term_ready=1. Accept on i_term_valid&o_term_ready: load sreg={0,i_term},
//   carry=0, bit_cnt=0, clr_flag=i_term_first, last_flag=i_term_last; if i_term_first, ovf=0.
//   Go SHIFT.
//  SHIFT: exactly ACC_W cycles, o_term_ready=0. Per cycle:
//   a=sreg[0], b=acc[0]&~clr_flag, cin=carry -> Full_adder -> sum,cout;
//   acc <= {sum, acc[ACC_W-1:1]}; sreg >>= 1; carry <= cout; bit_cnt++.
//   On cycle bit_cnt==ACC_W-1: ovf |= cout; clr_flag=0; next state DONE if last_flag else IDLE.
//  Result: acc = (acc_prev*~first + term) mod 2^ACC_W after the final SHIFT cycle.
//  Throughput: one term per ACC_W+1 cycles (accept cycle + ACC_W SHIFT cycles).
//  DONE: o_sum_valid=1, o_term_ready=0; o_sum/o_sum_ovf held stable until i_sum_ready=1;
//   on handshake -> IDLE (acc retained, o_sum_valid=0 next cycle).
//  o_sum always drives acc; consumers sample only when o_sum_valid=1 (mid-SHIFT value is partial).
//  Term without i_term_first after a completed sum continues accumulating onto retained acc;
//   ovf keeps its sticky value.
//  i_term_first & i_term_last on one term: sum = zero-extended term, ovf=0.
//  i_term_valid while not ready: ignored, producer must hold term/first/last stable.
//  i_sum_ready outside DONE: ignored.
//  o_busy = (state != IDLE).
// STRUCTURE
//  Shared package attn_pkg: ACC_W/DATA_W defaults, FSM encodings ST_IDLE=2'd0,
//   ST_SHIFT=2'd1, ST_DONE=2'd2; bit_cnt width $clog2(ACC_W).
//  One sub-module: Full_adder (existing 1-bit cell, instantiated once, carry flop external).
//  Controller holds FSM, bit counter, operand sreg, acc sreg, carry and flag flops.
// TESTING (DATA_W=8, ACC_W=8 unless stated)
//  1 terms 5(first),7,200(last) -> o_sum_valid with o_sum=212, o_sum_ovf=0;
//    o_term_ready low exactly 8 cycles after each accept.
//  2 terms 200(first),100(last) -> o_sum=44 (300 mod 256), o_sum_ovf=1; next sum with
//    first: 1(first,last) -> o_sum=1, o_sum_ovf=0.
//  3 single term 0xAB first&last, i_sum_ready low 5 cycles -> o_sum=0xAB held stable,
//    o_sum_valid=1, o_term_ready=0 throughout; cleared the cycle after i_sum_ready=1.
//  4 assert s_rst on 4th SHIFT cycle of a 3-term sum -> all outputs 0 immediately;
//    after release, 9(first,last) -> o_sum=9, ovf=0, no stale sum emitted.
//  5 ACC_W=16: 1000 terms of 255 (first on #1, last on #1000) -> o_sum=255000 mod 65536
//    =58392, o_sum_ovf=1; randomised i_term_valid gaps, check vs reference model.
//  6 sum 10(first,last) consumed, then 6(last, no first) -> o_sum=16, ovf unchanged.

Source files
------------

// File: rtl/attn_pkg.sv
// Shared definitions for the attention-score bit-serial accumulation path:
// default widths, FSM state encoding and the bit-counter width helper.
package attn_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width of a counter that must index every accumulator bit.
  function automatic int cntWidth(input int accW);
    return (accW > 1) ? $clog2(accW) : 1;
  endfunction

endpackage

// File: rtl/attn_bitserial_acc_ctrl_full_adder.sv
// Existing 1-bit full-adder cell. It is purely combinational; the carry
// flop that chains bits across clocks lives in the controller.
module Full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/attn_bitserial_acc_ctrl.sv
// Bit-serial accumulation controller. Each accepted term is added into the
// accumulator one bit per clock, LSB first, through a single Full_adder cell.
// The accumulator is a rotating shift register, so after ACC_W shift cycles
// it holds the new sum in its natural bit order.
module attn_bitserial_acc_ctrl
  import attn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic [DATA_W-1:0] i_term,
  input  logic              i_term_first,
  input  logic              i_term_last,
  input  logic              i_term_valid,
  output logic              o_term_ready,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_sum_ovf,
  output logic              o_sum_valid,
  input  logic              i_sum_ready,
  output logic              o_busy
);

  localparam int               CNT_W    = cntWidth(ACC_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ACC_W - 1);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_sreg;
  logic               r_carry;
  logic [CNT_W-1:0]   r_bitCnt;
  logic               r_clrFlag;
  logic               r_lastFlag;
  logic               r_ovf;

  logic               w_a;
  logic               w_b;
  logic               w_sum;
  logic               w_cout;
  logic               w_accept;
  logic               w_lastBit;

  // A new sum ignores the old accumulator contents by masking its bits off.
  assign w_a       = r_sreg[0];
  assign w_b       = r_acc[0] & ~r_clrFlag;
  assign w_accept  = i_term_valid & o_term_ready;
  assign w_lastBit = (r_bitCnt == LAST_BIT);

  Full_adder u_fullAdder (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Controller FSM plus all datapath registers: accept, shift, hold result.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_sreg     <= '0;
      r_carry    <= 1'b0;
      r_bitCnt   <= '0;
      r_clrFlag  <= 1'b0;
      r_lastFlag <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sreg     <= ACC_W'(i_term);
            r_carry    <= 1'b0;
            r_bitCnt   <= '0;
            r_clrFlag  <= i_term_first;
            r_lastFlag <= i_term_last;
            if (i_term_first) begin
              r_ovf <= 1'b0;
            end
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_acc    <= {w_sum, r_acc[ACC_W-1:1]};
          r_sreg   <= r_sreg >> 1;
          r_carry  <= w_cout;
          r_bitCnt <= r_bitCnt + CNT_W'(1);
          if (w_lastBit) begin
            r_ovf     <= r_ovf | w_cout;
            r_clrFlag <= 1'b0;
            r_state   <= r_lastFlag ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          if (i_sum_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_term_ready = (r_state == ST_IDLE) & ~s_rst;
  assign o_sum        = r_acc;
  assign o_sum_ovf    = r_ovf;
  assign o_sum_valid  = (r_state == ST_DONE);
  assign o_busy       = (r_state != ST_IDLE);

endmodule
